// File: rtl/move_control_pkg.sv
// Shared types and constants for the block-move controller: FSM states,
// direction codes and geometry constants.
package move_control_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SETTLE  = 3'd2,
    SPAWN   = 3'd3,
    ERASE   = 3'd4,
    STEP    = 3'd5,
    PAINT   = 3'd6,
    WAIT    = 3'd7
  } state_t;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int TILE_PIX      = 20;
  localparam int BLK_PER_GROUP = 5;
  localparam int SETTLE_CYCLES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/move_control_timer.sv
// Loadable down-counter: counts to zero after a load and holds there; done
// is high while the count is zero.
module move_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/move_control.sv
// Sequences one block move: capture random value, spawn a block, then STEPS
// rounds of erase / step / paint / frame wait. Optional move counter is
// enabled by defining MOVE_CTRL_MOVE_CNT_EN.
module move_control
  import move_control_pkg::*;
#(
  parameter int TILE_CYCLES = 400,
  parameter int TILES       = 5,
  parameter int STEPS       = 5,
  parameter int FRAME_WAIT  = 833333
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic [1:0]  dir_in,
  output logic [1:0]  dir,
  output logic        capture,
  output logic [9:0]  ld_blk,
  output logic        increment,
  output logic        draw_en,
  output logic        paint,
`ifdef MOVE_CTRL_MOVE_CNT_EN
  output logic [7:0]  moves_done,
`endif
  output state_t      state,
  output logic        busy
);

  localparam int PASS_CYCLES = TILES * TILE_CYCLES;
  localparam int MAX_LOAD    = max3(PASS_CYCLES, FRAME_WAIT, SETTLE_CYCLES);
  localparam int TW          = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;
  localparam int SW          = $clog2(STEPS + 1);

  state_t          state_next;
  logic            go_q;
  logic [2:0]      spawn_idx;
  logic [SW-1:0]   step_cnt;
  logic            timer_load;
  logic [TW-1:0]   timer_val;
  logic            timer_done;
  logic [3:0]      blk_idx;
  logic [9:0]      blk_onehot;

  // Timer holds (duration - 1) on entry so a state lasts exactly its duration.
  move_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign blk_idx    = {1'b0, spawn_idx} + (dir[0] ? 4'(BLK_PER_GROUP) : 4'd0);
  assign blk_onehot = 10'd1 << blk_idx;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go && !go_q) state_next = CAPTURE;
      CAPTURE: state_next = SETTLE;
      SETTLE:  if (timer_done) state_next = SPAWN;
      SPAWN:   state_next = ERASE;
      ERASE:   if (timer_done) state_next = STEP;
      STEP:    state_next = PAINT;
      PAINT:   if (timer_done) state_next = WAIT;
      WAIT:    if (timer_done) state_next = (step_cnt < SW'(STEPS)) ? ERASE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_load = (state_next != state);
    timer_val  = '0;
    case (state_next)
      SETTLE:        timer_val = TW'(SETTLE_CYCLES - 1);
      ERASE, PAINT:  timer_val = TW'(PASS_CYCLES - 1);
      WAIT:          timer_val = TW'(FRAME_WAIT - 1);
      default:       timer_val = '0;
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      go_q      <= 1'b1;
      dir       <= DIR_DOWN;
      spawn_idx <= '0;
      step_cnt  <= '0;
      capture   <= 1'b0;
      ld_blk    <= '0;
      increment <= 1'b0;
      draw_en   <= 1'b0;
      paint     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      go_q      <= go;
      if (state == IDLE && state_next == CAPTURE) dir <= dir_in;
      if (state_next == CAPTURE && state != CAPTURE) step_cnt <= '0;
      else if (state == STEP) step_cnt <= step_cnt + 1'b1;
      if (state == SPAWN)
        spawn_idx <= (spawn_idx == 3'(BLK_PER_GROUP - 1)) ? 3'd0 : spawn_idx + 3'd1;
      capture   <= (state_next == CAPTURE);
      ld_blk    <= (state_next == SPAWN) ? blk_onehot : '0;
      increment <= (state_next == STEP);
      draw_en   <= (state_next == ERASE) || (state_next == PAINT);
      paint     <= (state_next == PAINT);
      busy      <= (state_next != IDLE);
    end
  end

`ifdef MOVE_CTRL_MOVE_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      moves_done <= '0;
    end else if (state == WAIT && state_next == IDLE) begin
      moves_done <= moves_done + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_move_control.sv
// Bench for move_control: a negedge monitor pops expected pulse events
// (cycle, kind, value) from a scoreboard queue filled when each move starts.
module tb_move_control;
  import move_control_pkg::*;

  localparam int TILE_CYCLES = 4;
  localparam int TILES       = 5;
  localparam int STEPS       = 5;
  localparam int FRAME_WAIT  = 10;
  localparam int PASS        = TILES * TILE_CYCLES;
  localparam int GAP         = 1 + PASS + FRAME_WAIT + PASS;
  localparam int FIRST_INC   = 5 + PASS;
  localparam int MOVE_LEN    = FIRST_INC + (STEPS - 1) * GAP + 1 + PASS + FRAME_WAIT;
  localparam int K_CAP = 1, K_LD = 2, K_INC = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic [1:0] dir;
  logic       capture, increment, draw_en, paint, busy;
  logic [9:0] ld_blk;
  state_t     state;
`ifdef MOVE_CTRL_MOVE_CNT_EN
  logic [7:0] moves_done;
`endif

  move_control #(
    .TILE_CYCLES (TILE_CYCLES),
    .TILES       (TILES),
    .STEPS       (STEPS),
    .FRAME_WAIT  (FRAME_WAIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .dir_in     (dir_in),
    .dir        (dir),
    .capture    (capture),
    .ld_blk     (ld_blk),
    .increment  (increment),
    .draw_en    (draw_en),
    .paint      (paint),
`ifdef MOVE_CTRL_MOVE_CNT_EN
    .moves_done (moves_done),
`endif
    .state      (state),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [47:0] exp_q[$];
  int m_spawn = 0;
  logic [1:0] m_dir = 2'b00;
  int draw_cnt = 0;
  int paint_cnt = 0;
  int busy_cnt = 0;

  function automatic logic [47:0] mk_ev(input int c, input int k, input logic [9:0] v);
    logic [31:0] cc;
    logic [3:0]  kk;
    cc = c;
    kk = 4'(k);
    return {cc, kk, 2'b00, v};
  endfunction

  // Monitor: pulse events, pulse exclusivity, dir stability, draw counts.
  logic [47:0] obs_ev, exp_ev;
  logic        have_ev;
  int          npulse;
  always @(negedge clock) begin
    npulse = int'(capture) + int'(increment) + int'(ld_blk != 10'd0);
    if (npulse != 0) begin
      tests++;
      if (npulse !== 1) begin
        fails++;
        $display("FAIL pulse_exclusive cyc=%0d got %0d simultaneous pulses, need 1", cyc, npulse);
      end
    end
    have_ev = 1'b1;
    if (capture)              obs_ev = mk_ev(cyc, K_CAP, 10'd0);
    else if (increment)       obs_ev = mk_ev(cyc, K_INC, 10'd0);
    else if (ld_blk != 10'd0) obs_ev = mk_ev(cyc, K_LD, ld_blk);
    else                      have_ev = 1'b0;
    if (have_ev) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse got %h, need none", obs_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (obs_ev !== exp_ev) begin
          fails++;
          $display("FAIL pulse_event got %h, need %h", obs_ev, exp_ev);
        end
      end
    end
    if (busy) begin
      busy_cnt++;
      tests++;
      if (dir !== m_dir) begin
        fails++;
        $display("FAIL dir_stable cyc=%0d got %b, need %b", cyc, dir, m_dir);
      end
    end
    if (draw_en) draw_cnt++;
    if (draw_en && paint) paint_cnt++;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    m_spawn = 0;
  endtask

  task automatic do_move(input logic [1:0] d, output int c);
    int idx;
    logic [9:0] one;
    @(negedge clock);
    go = 1'b0;
    @(negedge clock);
    dir_in = d;
    go = 1'b1;
    c = cyc;
    m_dir = d;
    idx = (d[0] ? BLK_PER_GROUP : 0) + m_spawn;
    one = 10'd1 << idx;
    m_spawn = (m_spawn + 1) % BLK_PER_GROUP;
    draw_cnt = 0;
    paint_cnt = 0;
    exp_q.push_back(mk_ev(c + 1, K_CAP, 10'd0));
    exp_q.push_back(mk_ev(c + 4, K_LD, one));
    for (int k = 0; k < STEPS; k++) exp_q.push_back(mk_ev(c + FIRST_INC + k * GAP, K_INC, 10'd0));
  endtask

  task automatic wait_idle(output int c_end);
    c_end = -1;
    for (int i = 0; i < MOVE_LEN + 50; i++) begin
      @(negedge clock);
      if (!busy) begin
        c_end = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    go = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if ({capture, ld_blk, increment, draw_en, paint, busy, dir} !== 17'd0 || state !== IDLE) begin
      fails++;
      $display("FAIL reset_outputs got cap=%b ld=%h inc=%b de=%b p=%b busy=%b dir=%b st=%0d, need all 0",
               capture, ld_blk, increment, draw_en, paint, busy, dir, state);
    end
    reset = 1'b1;
    m_spawn = 0;
    busy_cnt = 0;
    repeat (8) @(negedge clock);
    tests++;
    if (busy_cnt !== 0) begin
      fails++;
      $display("FAIL reset_go_held got %0d busy cycles, need 0", busy_cnt);
    end
    go = 1'b0;
  endtask

  task automatic test_first_move();
    int c, c_end;
    do_move(DIR_LEFT, c);
    @(negedge clock);
    tests++;
    if (busy !== 1'b1 || capture !== 1'b1 || dir !== DIR_LEFT) begin
      fails++;
      $display("FAIL first_move_start got busy=%b cap=%b dir=%b, need 1 1 01", busy, capture, dir);
    end
    wait_idle(c_end);
    tests++;
    if (c_end !== c + MOVE_LEN) begin
      fails++;
      $display("FAIL first_move_end got cycle %0d, need %0d", c_end, c + MOVE_LEN);
    end
    tests++;
    if (draw_cnt !== STEPS * 2 * PASS || paint_cnt !== STEPS * PASS) begin
      fails++;
      $display("FAIL draw_cycles got draw=%0d paint=%0d, need %0d %0d",
               draw_cnt, paint_cnt, STEPS * 2 * PASS, STEPS * PASS);
    end
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL first_move_pending got %0d events left, need 0", exp_q.size());
    end
  endtask

  task automatic test_spawn_sequence();
    int c, c_end;
    do_reset();
    for (int m = 0; m < 6; m++) begin
      do_move(DIR_DOWN, c);
      wait_idle(c_end);
      tests++;
      if (c_end !== c + MOVE_LEN) begin
        fails++;
        $display("FAIL spawn_seq_end move=%0d got cycle %0d, need %0d", m, c_end, c + MOVE_LEN);
      end
    end
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL spawn_seq_pending got %0d events left, need 0", exp_q.size());
    end
  endtask

  task automatic test_midmove_ignore();
    int c, c_end;
    do_move(DIR_UP, c);
    c_end = -1;
    for (int i = 0; i < MOVE_LEN + 50; i++) begin
      @(negedge clock);
      if (!busy) begin
        c_end = cyc;
        break;
      end
      if (cyc < c + MOVE_LEN - 5) begin
        if ($urandom_range(0, 3) == 0) go = ~go;
        dir_in = 2'($urandom_range(0, 3));
      end else begin
        go = 1'b1;
      end
    end
    tests++;
    if (c_end !== c + MOVE_LEN) begin
      fails++;
      $display("FAIL midmove_end got cycle %0d, need %0d", c_end, c + MOVE_LEN);
    end
    busy_cnt = 0;
    repeat (10) @(negedge clock);
    tests++;
    if (busy_cnt !== 0 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL midmove_retrigger got busy=%0d pending=%0d, need 0 0", busy_cnt, exp_q.size());
    end
    go = 1'b0;
  endtask

  task automatic test_reset_abort();
    int c, tgt;
    do_move(DIR_RIGHT, c);
    tgt = c + FIRST_INC + 2 * GAP + 7;
    for (int i = 0; i < MOVE_LEN && cyc < tgt - 1; i++) @(negedge clock);
    tests++;
    if (draw_en !== 1'b1 || paint !== 1'b1 || exp_q.size() !== 2) begin
      fails++;
      $display("FAIL abort_precondition got de=%b p=%b pending=%0d, need 1 1 2",
               draw_en, paint, exp_q.size());
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if ({capture, ld_blk, increment, draw_en, paint, busy, dir} !== 17'd0 || state !== IDLE) begin
      fails++;
      $display("FAIL abort_outputs got cap=%b ld=%h inc=%b de=%b p=%b busy=%b dir=%b st=%0d, need all 0",
               capture, ld_blk, increment, draw_en, paint, busy, dir, state);
    end
    exp_q.delete();
    m_spawn = 0;
    @(negedge clock);
    reset = 1'b1;
    busy_cnt = 0;
    repeat (MOVE_LEN + 20) @(negedge clock);
    tests++;
    if (busy_cnt !== 0) begin
      fails++;
      $display("FAIL abort_no_restart got %0d busy cycles, need 0", busy_cnt);
    end
    go = 1'b0;
  endtask

`ifdef MOVE_CTRL_MOVE_CNT_EN
  task automatic test_move_count();
    int c, c_end;
    do_reset();
    tests++;
    if (moves_done !== 8'd0) begin
      fails++;
      $display("FAIL moves_reset got %0d, need 0", moves_done);
    end
    for (int m = 0; m < 256; m++) begin
      do_move(2'($urandom_range(0, 3)), c);
      wait_idle(c_end);
      if (m == 0) begin
        tests++;
        if (moves_done !== 8'd1) begin
          fails++;
          $display("FAIL moves_one got %0d, need 1", moves_done);
        end
      end
    end
    tests++;
    if (moves_done !== 8'd0) begin
      fails++;
      $display("FAIL moves_wrap got %0d, need 0", moves_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_move();
    test_spawn_sequence();
    test_midmove_ignore();
    test_reset_abort();
`ifdef MOVE_CTRL_MOVE_CNT_EN
    test_move_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
